// File: rtl/ascon_round_scheduler_pkg.sv
// Shared types and constants for the Ascon round scheduler.
// Optional abort input is enabled by ASCON_SCHED_ABORT_EN.
package ascon_round_scheduler_pkg;

  localparam int ROUND_W = 4;

  localparam logic [ROUND_W-1:0] P12_START  = 4'h0;
  localparam logic [ROUND_W-1:0] P6_START   = 4'h6;
  localparam logic [ROUND_W-1:0] ROUND_LAST = 4'hB;

  typedef enum logic {
    MODE_P12,
    MODE_P6
  } perm_mode_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FIRST,
    S_RUN,
    S_DONE
  } sched_state_t;

  function automatic logic [ROUND_W-1:0] start_round(
    input perm_mode_t m
  );
    return (m == MODE_P6) ? P6_START : P12_START;
  endfunction

endpackage

// File: rtl/ascon_round_scheduler_round_counter.sv
// Loadable up-counter holding the Ascon round index.
// Flags the final round so the scheduler can stop without overflow.
module round_counter
  import ascon_round_scheduler_pkg::*;
(
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               load,
  input  logic [ROUND_W-1:0] load_val,
  input  logic               inc,
  output logic [ROUND_W-1:0] count_o,
  output logic               last_o
);

  logic [ROUND_W-1:0] cnt_q;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (inc) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign count_o = cnt_q;
  assign last_o  = (cnt_q == ROUND_LAST);

endmodule

// File: rtl/ascon_round_scheduler.sv
// Ascon permutation round scheduler: p12 or p6, one round per clock.
// Define ASCON_SCHED_ABORT_EN to add the abort_i input.
module ascon_round_scheduler
  import ascon_round_scheduler_pkg::*;
(
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               start_i,
  input  logic               mode_i,
`ifdef ASCON_SCHED_ABORT_EN
  input  logic               abort_i,
`endif
  output logic               ready_o,
  output logic [ROUND_W-1:0] round_o,
  output logic               data_sel_o,
  output logic               en_state_o,
  output logic               done_o
);

  sched_state_t       state_q;
  sched_state_t       state_d;
  logic               load;
  logic [ROUND_W-1:0] load_val;
  logic               inc;
  logic               last;
  logic               ready_d;
  logic               sel_d;
  logic               en_d;
  logic               done_d;

  round_counter u_cnt (
    .clock_i  (clock_i),
    .reset_i  (reset_i),
    .load     (load),
    .load_val (load_val),
    .inc      (inc),
    .count_o  (round_o),
    .last_o   (last)
  );

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      ready_o    <= 1'b1;
      data_sel_o <= 1'b0;
      en_state_o <= 1'b0;
      done_o     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ready_o    <= ready_d;
      data_sel_o <= sel_d;
      en_state_o <= en_d;
      done_o     <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    load_val = P12_START;
    inc      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d  = S_FIRST;
          load     = 1'b1;
          load_val = start_round(perm_mode_t'(mode_i));
        end
      end
      S_FIRST: begin
        state_d = S_RUN;
        inc     = 1'b1;
      end
      // Compare before increment: index holds at ROUND_LAST
      S_RUN: begin
        if (last) state_d = S_DONE;
        else      inc     = 1'b1;
      end
      S_DONE: begin
        state_d  = S_IDLE;
        load     = 1'b1;
        load_val = P12_START;
      end
      default: state_d = S_IDLE;
    endcase
`ifdef ASCON_SCHED_ABORT_EN
    if (abort_i &&
        (state_q == S_FIRST || state_q == S_RUN)) begin
      state_d  = S_IDLE;
      load     = 1'b1;
      load_val = P12_START;
      inc      = 1'b0;
    end
`endif
  end

  // Outputs are decoded from the next state and registered
  always_comb begin
    ready_d = (state_d == S_IDLE);
    sel_d   = (state_d == S_FIRST);
    en_d    = (state_d == S_FIRST) || (state_d == S_RUN);
    done_d  = (state_d == S_DONE);
  end

endmodule

// File: tb/tb_ascon_round_scheduler.sv
// Directed self-checking bench for ascon_round_scheduler.
// Abort scenario is built when ASCON_SCHED_ABORT_EN is defined.
module tb_ascon_round_scheduler;

  logic       clock_i = 1'b0;
  logic       reset_i = 1'b1;
  logic       start_i = 1'b0;
  logic       mode_i  = 1'b0;
`ifdef ASCON_SCHED_ABORT_EN
  logic       abort_i = 1'b0;
`endif
  logic       ready_o;
  logic [3:0] round_o;
  logic       data_sel_o;
  logic       en_state_o;
  logic       done_o;

  int tests = 0;
  int fails = 0;

  ascon_round_scheduler dut (
    .clock_i    (clock_i),
    .reset_i    (reset_i),
    .start_i    (start_i),
    .mode_i     (mode_i),
`ifdef ASCON_SCHED_ABORT_EN
    .abort_i    (abort_i),
`endif
    .ready_o    (ready_o),
    .round_o    (round_o),
    .data_sel_o (data_sel_o),
    .en_state_o (en_state_o),
    .done_o     (done_o)
  );

  always #5 clock_i = ~clock_i;

  task automatic step();
    @(posedge clock_i);
    #1;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    start_i = 1'b1;
    step();
    step();
    tests++;
    if ({ready_o, round_o, data_sel_o, en_state_o, done_o}
        !== {1'b1, 4'h0, 1'b0, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL reset: rdy=%b rnd=%h sel=%b en=%b done=%b want 1 0 0 0 0",
               ready_o, round_o, data_sel_o, en_state_o, done_o);
    end
    reset_i = 1'b0;
    start_i = 1'b0;
    step();
    tests++;
    if (ready_o !== 1'b1 || en_state_o !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: rdy=%b en=%b want rdy=1 en=0",
               ready_o, en_state_o);
    end
  endtask

  // One full permutation; noise adds ignored starts and mode toggles
  task automatic run_and_check(input logic m, input bit noise);
    logic [3:0] exp_r;
    int         n;
    exp_r   = m ? 4'h6 : 4'h0;
    n       = m ? 6 : 12;
    start_i = 1'b1;
    mode_i  = m;
    step();
    start_i = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (noise) begin
        mode_i  = ~mode_i;
        start_i = (exp_r == 4'h3);
      end
      tests++;
      if (round_o !== exp_r || en_state_o !== 1'b1 ||
          data_sel_o !== (i == 0) || done_o !== 1'b0 ||
          ready_o !== 1'b0) begin
        fails++;
        $display("FAIL run m%0d cyc%0d: rnd=%h en=%b sel=%b done=%b rdy=%b want rnd=%h en=1 sel=%b done=0 rdy=0",
                 m, i, round_o, en_state_o, data_sel_o, done_o,
                 ready_o, exp_r, (i == 0));
      end
      exp_r = exp_r + 4'h1;
      step();
    end
    if (noise) start_i = 1'b1;
    tests++;
    if (done_o !== 1'b1 || en_state_o !== 1'b0 ||
        round_o !== 4'hB || ready_o !== 1'b0) begin
      fails++;
      $display("FAIL done m%0d: done=%b en=%b rnd=%h rdy=%b want 1 0 b 0",
               m, done_o, en_state_o, round_o, ready_o);
    end
    step();
    start_i = 1'b0;
    tests++;
    if (ready_o !== 1'b1 || round_o !== 4'h0 ||
        done_o !== 1'b0 || en_state_o !== 1'b0) begin
      fails++;
      $display("FAIL post_done m%0d: rdy=%b rnd=%h done=%b en=%b want 1 0 0 0",
               m, ready_o, round_o, done_o, en_state_o);
    end
  endtask

  task automatic test_p12();
    run_and_check(1'b0, 1'b0);
  endtask

  task automatic test_p6();
    run_and_check(1'b1, 1'b0);
  endtask

  task automatic test_ignored();
    run_and_check(1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step();
      tests++;
      if (ready_o !== 1'b1 || en_state_o !== 1'b0 ||
          done_o !== 1'b0) begin
        fails++;
        $display("FAIL no_rerun cyc%0d: rdy=%b en=%b done=%b want 1 0 0",
                 i, ready_o, en_state_o, done_o);
      end
    end
  endtask

  task automatic test_back_to_back();
    run_and_check(1'b1, 1'b0);
    run_and_check(1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_run();
    start_i = 1'b1;
    mode_i  = 1'b0;
    step();
    start_i = 1'b0;
    for (int i = 0; i < 7; i++) step();
    tests++;
    if (round_o !== 4'h7) begin
      fails++;
      $display("FAIL rst_pre: rnd=%h want 7", round_o);
    end
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    tests++;
    if ({ready_o, round_o, data_sel_o, en_state_o, done_o}
        !== {1'b1, 4'h0, 1'b0, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL rst_mid: rdy=%b rnd=%h sel=%b en=%b done=%b want 1 0 0 0 0",
               ready_o, round_o, data_sel_o, en_state_o, done_o);
    end
    for (int i = 0; i < 14; i++) begin
      step();
      tests++;
      if (done_o !== 1'b0 || en_state_o !== 1'b0) begin
        fails++;
        $display("FAIL rst_no_done cyc%0d: done=%b en=%b want 0 0",
                 i, done_o, en_state_o);
      end
    end
  endtask

`ifdef ASCON_SCHED_ABORT_EN
  task automatic test_abort();
    start_i = 1'b1;
    mode_i  = 1'b1;
    step();
    start_i = 1'b0;
    for (int i = 0; i < 3; i++) step();
    tests++;
    if (round_o !== 4'h9) begin
      fails++;
      $display("FAIL abort_pre: rnd=%h want 9", round_o);
    end
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    tests++;
    if (ready_o !== 1'b1 || round_o !== 4'h0 ||
        en_state_o !== 1'b0 || done_o !== 1'b0) begin
      fails++;
      $display("FAIL abort: rdy=%b rnd=%h en=%b done=%b want 1 0 0 0",
               ready_o, round_o, en_state_o, done_o);
    end
    for (int i = 0; i < 8; i++) begin
      step();
      tests++;
      if (done_o !== 1'b0) begin
        fails++;
        $display("FAIL abort_no_done cyc%0d: done=%b want 0",
                 i, done_o);
      end
    end
    run_and_check(1'b0, 1'b0);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_p12();
    test_p6();
    test_ignored();
    test_back_to_back();
    test_reset_mid_run();
`ifdef ASCON_SCHED_ABORT_EN
    test_abort();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ascon_round_scheduler.md
Name: ascon_round_scheduler

Overview:
Sequences the Ascon permutation datapath (constant addition, substitution layer, linear diffusion) one round per clock. It drives the round index into constant addition and the state-register mux/enable. It runs either p12 (rounds 0..11) or p6 (rounds 6..11) per request, and signals completion to the top-level mode FSM (init, associated data, plaintext, finalisation).

Parameters:
ROUND_W, 4, width of round index (rounds 0x0..0xB)
ROUND_LAST, 4'hB, index of final round for both p12 and p6

Ports:
clock_i  input  1  system clock, rising edge
reset_i  input  1  synchronous, active-high reset
start_i  input  1  permutation request; accepted only while ready_o=1
mode_i  input  1  0 = p12 (start round 0x0), 1 = p6 (start round 0x6); sampled only on accepted start
ready_o  output  1  1 in IDLE only
round_o  output  4  round index to constant addition
data_sel_o  output  1  1 = datapath mux takes external input state; 0 = state-register feedback
en_state_o  output  1  state register write enable
done_o  output  1  single-cycle pulse after final round is registered

Behaviour:
- Clock and reset: single clock clock_i; reset_i is synchronous and active-high. All outputs are registered.
- Reset values: FSM=IDLE, ready_o=1, round_o=0x0, data_sel_o=0, en_state_o=0, done_o=0.
- FSM states: IDLE, FIRST, RUN, DONE.
- IDLE:
  - ready_o=1, en_state_o=0.
  - start_i=1 at edge t: latch mode_i, load round_o with 0x0 (p12) or 0x6 (p6), go to FIRST.
- FIRST (1 cycle):
  - data_sel_o=1, en_state_o=1, round_o=start round, ready_o=0.
  - Next edge: round_o+1, go to RUN.
- RUN:
  - data_sel_o=0, en_state_o=1.
  - round_o increments by 1 each cycle.
  - In the cycle where round_o==ROUND_LAST, next edge goes to DONE.
- DONE (1 cycle):
  - done_o=1, en_state_o=0, round_o holds 0xB.
  - Next edge: IDLE, round_o=0x0.
- Latency: start accepted at edge t; en_state_o is high for 12 (p12) or 6 (p6) consecutive cycles from t+1; done_o is high in cycle t+13 (p12) or t+7 (p6). Next start is accepted at the earliest one cycle after done_o.
- Boundary conditions:
  - start_i while not IDLE (including DONE) is ignored; no queuing.
  - mode_i changes mid-run have no effect.
  - round_o never exceeds 0xB; no wrap-around to 0x0 while busy.
  - reset_i mid-run returns to IDLE with reset values on the next edge; no done_o pulse.
  - start_i and reset_i both high: reset wins.
- Arithmetic: round_o is a 4-bit unsigned increment. Overflow cannot occur because the last-round compare precedes the increment.

Optional Feature:
- Macro: ASCON_SCHED_ABORT_EN.
- Defined:
  - Adds port abort_i (input, 1 bit).
  - abort_i=1 in FIRST or RUN forces IDLE on the next edge; en_state_o=0 from that edge; no done_o; round_o=0x0.
  - abort_i is ignored in IDLE and DONE.
  - reset_i has priority over abort_i.
- Undefined: no abort_i port; a permutation always runs to completion.

Decomposition:
- ascon_pack additions:
  - typedef enum logic {MODE_P12, MODE_P6} perm_mode_t
  - typedef enum logic[1:0] {S_IDLE, S_FIRST, S_RUN, S_DONE} sched_state_t
  - constants P12_START=4'h0, P6_START=4'h6, ROUND_LAST=4'hB
- One sub-module: round_counter, a loadable 4-bit up-counter.
  - Inputs: load, load value, increment enable.
  - Output: last_o flag (count==ROUND_LAST).
  - Instantiated once; the FSM in ascon_round_scheduler uses last_o for the RUN->DONE transition.

Test Plan:
- Reset: hold reset_i 2 cycles -> ready_o=1, round_o=0x0, en_state_o=0, done_o=0, data_sel_o=0.
- p12 run: start_i=1, mode_i=0 for 1 cycle -> data_sel_o=1 for exactly 1 cycle with round_o=0x0; round_o steps 0x0..0xB with en_state_o high 12 cycles; done_o one pulse 13 cycles after start edge; then ready_o=1.
- p6 run: start_i=1, mode_i=1 -> round_o steps 0x6..0xB; en_state_o high 6 cycles; done_o 7 cycles after start edge.
- Ignored requests: start_i pulses at rounds 0x3 and in DONE cycle, mode_i toggled mid-run -> sequence identical to plain p12; no second run until start_i is reasserted in IDLE.
- Reset mid-run: reset_i at round_o=0x7 -> next cycle IDLE, round_o=0x0, en_state_o=0; no done_o pulse observed.
- ASCON_SCHED_ABORT_EN: abort_i at round_o=0x9 (p6) -> IDLE next edge, no done_o; subsequent p12 start runs normally 0x0..0xB.
